// File: rtl/cmd_scheduler_if.sv
// Command handshake between the scheduler (master) and the operation datapath (slave).
interface cmd_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  logic            cmd_valid_o;
  logic [NREQ-1:0] cmd_o;
  logic            cmd_ready_i;
  logic            done_i;

  modport master (output cmd_valid_o, output cmd_o, input cmd_ready_i, input done_i);
  modport slave  (input cmd_valid_o, input cmd_o, output cmd_ready_i, output done_i);
endinterface

// File: rtl/cmd_scheduler.sv
// Captures one-cycle command requests into pending flags and issues them one at a
// time, round-robin, over a valid/ready + done handshake with overrun and hang recovery.
module cmd_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NREQ-1:0]  req_i,
  input  logic             clr_i,
  cmd_scheduler_if.master  cmd,
  output logic             busy_o,
  output logic [NREQ-1:0]  pending_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             timeout_o
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT);
  localparam int unsigned ADD_W = $clog2(NREQ + 1);
  localparam int unsigned SUM_W = CNT_W + ADD_W;
  localparam logic [SUM_W-1:0] CNT_MAX  = {{ADD_W{1'b0}}, {CNT_W{1'b1}}};
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic [TMR_W-1:0] timer_q;

  logic [IDX_W-1:0] idx_c;
  logic [IDX_W-1:0] grant_idx_c;
  logic             found_c;
  logic             hs_c;
  logic [NREQ-1:0]  clear_mask_c;
  logic [NREQ-1:0]  drop_mask_c;
  logic [ADD_W-1:0] ndrop_c;
  logic [SUM_W-1:0] sum_c;
  logic [CNT_W-1:0] drop_next_c;

  // Round-robin search starting one past the last granted index.
  always_comb begin
    idx_c       = '0;
    grant_idx_c = ptr_q;
    found_c     = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx_c = IDX_W'((32'(ptr_q) + i + 1) % NREQ);
      if (!found_c && pending_o[idx_c]) begin
        grant_idx_c = idx_c;
        found_c     = 1'b1;
      end
    end
  end

  // A request landing on its own handshake re-arms the flag instead of counting as a drop.
  always_comb begin
    hs_c         = (state_q == ISSUE) && cmd.cmd_ready_i;
    clear_mask_c = hs_c ? cmd.cmd_o : '0;
    drop_mask_c  = req_i & pending_o & ~clear_mask_c;
    ndrop_c      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      ndrop_c = ndrop_c + ADD_W'(drop_mask_c[i]);
    end
    sum_c       = SUM_W'(drop_cnt_o) + SUM_W'(ndrop_c);
    drop_next_c = (sum_c > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum_c[CNT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      ptr_q           <= IDX_W'(NREQ - 1);
      grant_q         <= '0;
      timer_q         <= '0;
      pending_o       <= '0;
      drop_cnt_o      <= '0;
      timeout_o       <= 1'b0;
      busy_o          <= 1'b0;
      cmd.cmd_valid_o <= 1'b0;
      cmd.cmd_o       <= '0;
    end else if (clr_i) begin
      // Pointer is deliberately kept so fairness survives a clear.
      state_q         <= IDLE;
      timer_q         <= '0;
      pending_o       <= '0;
      drop_cnt_o      <= '0;
      timeout_o       <= 1'b0;
      busy_o          <= 1'b0;
      cmd.cmd_valid_o <= 1'b0;
      cmd.cmd_o       <= '0;
    end else begin
      pending_o  <= (pending_o & ~clear_mask_c) | req_i;
      drop_cnt_o <= drop_next_c;
      case (state_q)
        IDLE: begin
          if (|pending_o) begin
            grant_q         <= grant_idx_c;
            cmd.cmd_o       <= ONE_HOT0 << grant_idx_c;
            cmd.cmd_valid_o <= 1'b1;
            busy_o          <= 1'b1;
            state_q         <= ISSUE;
          end
        end
        ISSUE: begin
          if (hs_c) begin
            cmd.cmd_valid_o <= 1'b0;
            ptr_q           <= grant_q;
            timer_q         <= '0;
            state_q         <= WAIT;
          end
        end
        WAIT: begin
          // done wins over a timeout expiring in the same cycle.
          if (cmd.done_i) begin
            cmd.cmd_o <= '0;
            busy_o    <= 1'b0;
            state_q   <= IDLE;
          end else if (timer_q == TMR_LAST) begin
            timeout_o <= 1'b1;
            cmd.cmd_o <= '0;
            busy_o    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: begin
          cmd.cmd_valid_o <= 1'b0;
          cmd.cmd_o       <= '0;
          busy_o          <= 1'b0;
          state_q         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Scoreboard bench for cmd_scheduler: expected grants are queued at stimulus time
// and compared at each handshake; timing and status outputs are checked per cycle.
module tb_cmd_scheduler;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [NREQ-1:0]  req_i;
  logic             clr_i;
  logic             busy_o;
  logic [NREQ-1:0]  pending_o;
  logic [CNT_W-1:0] drop_cnt_o;
  logic             timeout_o;

  cmd_scheduler_if #(.NREQ(NREQ)) cif ();

  cmd_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .clr_i      (clr_i),
    .cmd        (cif),
    .busy_o     (busy_o),
    .pending_o  (pending_o),
    .drop_cnt_o (drop_cnt_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int hs_cnt   = 0;
  int last_hs  = 0;
  int dp_dly   = 0;
  int dp_cnt   = 0;
  int t0;
  int w;
  logic [NREQ-1:0] exp_q[$];
  int              hs_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: log a handshake seen this cycle, advance, then model the datapath done pulse.
  task automatic step();
    logic [NREQ-1:0] e;
    if (cif.cmd_valid_o && cif.cmd_ready_i && rst_ni) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      last_hs = cyc;
      if (exp_q.size() == 0) check("sb_unexpected", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        check("sb_cmd", 32'(cif.cmd_o), 32'(e));
      end
      dp_cnt = dp_dly;
    end
    @(posedge clk_i);
    #1;
    cyc++;
    cif.done_i = 1'b0;
    if (dp_cnt > 0) begin
      dp_cnt--;
      if (dp_cnt == 0) cif.done_i = 1'b1;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_hs(input int target);
    int k;
    k = 0;
    while (hs_cnt < target && k < 60) begin
      step();
      k++;
    end
    check("hs_count", 32'(hs_cnt), 32'(target));
  endtask

  task automatic do_reset();
    rst_ni          = 1'b0;
    req_i           = '0;
    clr_i           = 1'b0;
    cif.cmd_ready_i = 1'b0;
    cif.done_i      = 1'b0;
    dp_cnt          = 0;
    dp_dly          = 0;
    exp_q.delete();
    steps(2);
    rst_ni = 1'b1;
    step();
    hs_cnt = 0;
    hs_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_ni          = 1'b0;
    req_i           = '0;
    clr_i           = 1'b0;
    cif.cmd_ready_i = 1'b0;
    cif.done_i      = 1'b0;
    do_reset();

    check("rst_valid",   32'(cif.cmd_valid_o), 0);
    check("rst_cmd",     32'(cif.cmd_o), 0);
    check("rst_busy",    32'(busy_o), 0);
    check("rst_pending", 32'(pending_o), 0);
    check("rst_drop",    32'(drop_cnt_o), 0);
    check("rst_timeout", 32'(timeout_o), 0);

    // Single request, ready tied high, done two cycles after handshake.
    cif.cmd_ready_i = 1'b1;
    dp_dly = 2;
    req_i = 4'b0001; exp_q.push_back(4'b0001); t0 = cyc;
    step(); req_i = '0;
    check("t1_pend_t1",  32'(pending_o), 32'h1);
    check("t1_valid_t1", 32'(cif.cmd_valid_o), 0);
    step();
    check("t1_valid_t2", 32'(cif.cmd_valid_o), 1);
    check("t1_cmd_t2",   32'(cif.cmd_o), 32'h1);
    check("t1_pend_t2",  32'(pending_o), 32'h1);
    check("t1_lat",      32'(cyc - t0), 2);
    step();
    check("t1_valid_t3", 32'(cif.cmd_valid_o), 0);
    check("t1_pend_t3",  32'(pending_o), 0);
    check("t1_busy_t3",  32'(busy_o), 1);
    step();
    check("t1_busy_t4",  32'(busy_o), 1);
    step();
    check("t1_busy_t5",  32'(busy_o), 0);
    check("t1_cmd_t5",   32'(cif.cmd_o), 0);

    // All four at once: round-robin order, three cycles apart, nothing dropped.
    do_reset();
    cif.cmd_ready_i = 1'b1;
    dp_dly = 1;
    req_i = 4'b1111;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    step(); req_i = '0;
    wait_hs(4);
    for (int i = 1; i < 4; i++)
      if (hs_cyc.size() > i) check("t2_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 3);
    steps(3);
    check("t2_drop", 32'(drop_cnt_o), 0);
    check("t2_busy", 32'(busy_o), 0);

    // Overrun on wr while unaccepted, then saturation.
    do_reset();
    req_i = 4'b0010; exp_q.push_back(4'b0010);
    step(); req_i = '0;
    step(); req_i = 4'b0010;
    step(); req_i = '0;
    step(); req_i = 4'b0010;
    step(); req_i = '0;
    check("t3_drop2",   32'(drop_cnt_o), 2);
    check("t3_pend",    32'(pending_o), 32'h2);
    check("t3_cmd",     32'(cif.cmd_o), 32'h2);
    cif.cmd_ready_i = 1'b1;
    dp_dly = 1;
    wait_hs(1);
    steps(4);
    check("t3_one_wr",  32'(hs_cnt), 1);
    check("t3_idle",    32'(busy_o), 0);
    cif.cmd_ready_i = 1'b0;
    req_i = 4'b0010;
    steps(301);
    req_i = '0;
    check("t3_sat",     32'(drop_cnt_o), 255);
    check("t3_holding", 32'(cif.cmd_valid_o), 1);
    clr_i = 1'b1; step(); clr_i = 1'b0;
    check("t3_clr_drop",  32'(drop_cnt_o), 0);
    check("t3_clr_pend",  32'(pending_o), 0);
    check("t3_clr_valid", 32'(cif.cmd_valid_o), 0);

    // Withheld done: timeout after TIMEOUT cycles in WAIT, next command proceeds.
    do_reset();
    cif.cmd_ready_i = 1'b1;
    dp_dly = 0;
    req_i = 4'b0001; exp_q.push_back(4'b0001);
    step(); req_i = '0;
    wait_hs(1);
    w = last_hs + 1;
    req_i = 4'b0100; exp_q.push_back(4'b0100);
    step(); req_i = '0;
    while (cyc < w + int'(TIMEOUT) - 1) step();
    check("t4_to_early", 32'(timeout_o), 0);
    check("t4_busy_pre", 32'(busy_o), 1);
    dp_dly = 1;
    step();
    check("t4_to_set",   32'(timeout_o), 1);
    check("t4_idle",     32'(busy_o), 0);
    check("t4_pend",     32'(pending_o), 32'h4);
    step();
    check("t4_next_v",   32'(cif.cmd_valid_o), 1);
    check("t4_next_cmd", 32'(cif.cmd_o), 32'h4);
    wait_hs(2);
    steps(3);
    check("t4_to_stick", 32'(timeout_o), 1);
    clr_i = 1'b1; step(); clr_i = 1'b0;
    check("t4_to_clr",   32'(timeout_o), 0);

    // Clear while a command is offered; a request in the clear cycle is lost.
    do_reset();
    req_i = 4'b0110;
    step(); req_i = '0;
    step();
    check("t5_valid", 32'(cif.cmd_valid_o), 1);
    check("t5_cmd",   32'(cif.cmd_o), 32'h2);
    check("t5_pend",  32'(pending_o), 32'h6);
    clr_i = 1'b1; req_i = 4'b0001;
    step(); clr_i = 1'b0; req_i = '0;
    check("t5_wd_valid", 32'(cif.cmd_valid_o), 0);
    check("t5_wd_pend",  32'(pending_o), 0);
    check("t5_wd_busy",  32'(busy_o), 0);
    check("t5_wd_cmd",   32'(cif.cmd_o), 0);
    step();
    check("t5_req_lost", 32'(pending_o), 0);
    check("t5_no_issue", 32'(cif.cmd_valid_o), 0);

    // rd request coinciding with its own handshake is kept and reissued.
    do_reset();
    req_i = 4'b0100; exp_q.push_back(4'b0100);
    step(); req_i = '0;
    step();
    cif.cmd_ready_i = 1'b1; dp_dly = 1;
    req_i = 4'b0100; exp_q.push_back(4'b0100);
    step(); req_i = '0;
    check("t6_pend_kept", 32'(pending_o), 32'h4);
    check("t6_no_drop",   32'(drop_cnt_o), 0);
    wait_hs(2);
    steps(3);
    check("t6_pend_done", 32'(pending_o), 0);

    // Asynchronous reset in the middle of WAIT.
    do_reset();
    cif.cmd_ready_i = 1'b1; dp_dly = 0;
    req_i = 4'b0011; exp_q.push_back(4'b0001);
    step(); req_i = '0;
    wait_hs(1);
    step();
    check("t7_busy_wait", 32'(busy_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    check("t7_busy",    32'(busy_o), 0);
    check("t7_valid",   32'(cif.cmd_valid_o), 0);
    check("t7_cmd",     32'(cif.cmd_o), 0);
    check("t7_pend",    32'(pending_o), 0);
    check("t7_drop",    32'(drop_cnt_o), 0);
    check("t7_timeout", 32'(timeout_o), 0);
    cif.cmd_ready_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step();

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
